// File: rtl/seq_detector_param_pkg.sv
// Shared constants for the parametrised sequence detector: default geometry,
// detection-mode encoding and a sizing helper.
package seq_detector_param_pkg;

  localparam int DEF_PAT_LEN = 4;
  localparam int DEF_CNT_W   = 8;
  localparam logic [DEF_PAT_LEN-1:0] DEF_RST_PAT = 4'b1010;

  typedef enum logic {
    MODE_NONOVL  = 1'b0,
    MODE_OVERLAP = 1'b1
  } mode_e;

  // Bits needed to hold a fill level in the range 0..n inclusive.
  function automatic int fill_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// Bit-history shift register with a fill counter; reports combinationally
// whether the window would be full once the presented bit is shifted in.
module seq_hist_shift
  import seq_detector_param_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_i,
  input  logic               x_i,
  input  logic               flush_i,
  input  logic               restart_i,
  output logic [PAT_LEN-1:0] hist_nxt_o,
  output logic               full_nxt_o
);

  localparam int FILL_W = fill_width(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  assign hist_nxt_o = {hist_q[PAT_LEN-2:0], x_i};
  assign full_nxt_o = (fill_q >= FILL_W'(PAT_LEN - 1));

  // restart clears only the fill level; the stale history is masked by fill.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = hist_nxt_o;
      if (restart_i)
        fill_d = '0;
      else if (full_nxt_o)
        fill_d = FILL_W'(PAT_LEN);
      else
        fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control, a registered
// one-cycle match pulse and a saturating match counter.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter int                 CNT_W   = DEF_CNT_W,
  parameter logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(DEF_RST_PAT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               pat_load,
  input  logic               overlap,
  input  logic               clr_count,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_nxt;
  logic               full_nxt;
  logic               accept, hit, restart;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mode_e              mode;

  assign mode    = mode_e'(overlap);
  // A pattern load takes priority and drops any bit presented alongside it.
  assign accept  = x_valid & ~pat_load;
  assign hit     = accept & full_nxt & (hist_nxt == pat_q);
  assign restart = hit & (mode == MODE_NONOVL);

  seq_hist_shift #(
    .PAT_LEN(PAT_LEN)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .shift_i   (accept),
    .x_i       (x),
    .flush_i   (pat_load),
    .restart_i (restart),
    .hist_nxt_o(hist_nxt),
    .full_nxt_o(full_nxt)
  );

  always_comb begin
    pat_d = pat_load ? pattern : pat_q;
    z_d   = hit;
    if (clr_count)
      cnt_d = '0;
    else if (hit)
      cnt_d = sat_inc(cnt_q);
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= RST_PAT;
      z_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      z_q   <= z_d;
      cnt_q <= cnt_d;
    end
  end

  assign z           = z_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset, x, x_valid, pat_load, overlap, clr_count;
  logic [3:0] pattern;
  logic       z, z2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(4), .CNT_W(8), .RST_PAT(4'b1010)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pattern(pattern),
    .pat_load(pat_load), .overlap(overlap), .clr_count(clr_count),
    .z(z), .match_count(cnt)
  );

  seq_detector_param #(.PAT_LEN(4), .CNT_W(2), .RST_PAT(4'b1010)) dut2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pattern(pattern),
    .pat_load(pat_load), .overlap(overlap), .clr_count(clr_count),
    .z(z2), .match_count(cnt2)
  );

  int nchk  = 0;
  int nfail = 0;

  // Reference model: bits accepted since the last flush, newest at the back.
  bit         mq[$];
  logic [3:0] mpat;
  logic       mz;
  int         mc8, mc2;

  typedef struct {
    bit   rst;
    logic xb;
    logic v;
    logic ov;
    logic clr;
    logic ez;
    int   ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic xb, input logic v, input logic pl,
                            input logic [3:0] pat, input logic ov, input logic clr);
    logic hit;
    hit = 1'b0;
    if (pl) begin
      mpat = pat;
      mq.delete();
    end else if (v) begin
      mq.push_back(xb);
      if (mq.size() > 4) void'(mq.pop_front());
      if (mq.size() == 4 && {mq[0], mq[1], mq[2], mq[3]} == mpat) hit = 1'b1;
      if (hit && !ov) mq.delete();
    end
    mz = hit;
    if (clr) begin
      mc8 = 0;
      mc2 = 0;
    end else if (hit) begin
      mc8 = (mc8 < 255) ? mc8 + 1 : 255;
      mc2 = (mc2 < 3) ? mc2 + 1 : 3;
    end
  endtask

  task automatic step(input logic xb, input logic v, input logic pl,
                      input logic [3:0] pat, input logic ov, input logic clr);
    @(negedge clk);
    x = xb; x_valid = v; pat_load = pl; pattern = pat; overlap = ov; clr_count = clr;
    model_step(xb, v, pl, pat, ov, clr);
    @(posedge clk);
    #1;
    chk("z", z, mz);
    chk("z2", z2, mz);
    chk("count", cnt, mc8);
    chk("count2", cnt2, mc2);
  endtask

  task automatic bitin(input logic xb, input logic ov);
    step(xb, 1'b1, 1'b0, 4'b0000, ov, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    x_valid = 1'b0; pat_load = 1'b0; clr_count = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_z", {z, z2}, 0);
    chk("rst_async_count", {cnt, cnt2}, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_z", {z, z2}, 0);
    chk("rst_hold_count", {cnt, cnt2}, 0);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    mpat = 4'b1010;
    mz = 1'b0;
    mc8 = 0;
    mc2 = 0;
  endtask

  function automatic void add(input bit r, input logic xb, input logic v, input logic ov,
                              input logic ez, input int ecnt);
    vec_t e;
    e.rst = r; e.xb = xb; e.v = v; e.ov = ov; e.clr = 1'b0; e.ez = ez; e.ecnt = ecnt;
    tbl.push_back(e);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int r;
    reset = 1'b1; x = 1'b0; x_valid = 1'b0; pat_load = 1'b0; overlap = 1'b1;
    clr_count = 1'b0; pattern = 4'b0000;
    mpat = 4'b1010; mz = 1'b0; mc8 = 0; mc2 = 0;
    repeat (2) @(posedge clk);

    // T1: overlap, 0,0,1,0,1,0,1,0
    add(1, 0, 1, 1, 0, 0); add(0, 0, 1, 1, 0, 0); add(0, 1, 1, 1, 0, 0); add(0, 0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0); add(0, 0, 1, 1, 1, 1); add(0, 1, 1, 1, 0, 1); add(0, 0, 1, 1, 1, 2);
    // T2: non-overlap, same stream
    add(1, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 1, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0); add(0, 0, 1, 0, 1, 1); add(0, 1, 1, 0, 0, 1); add(0, 0, 1, 0, 0, 1);
    // T4: x_valid gaps inside 1,0,1,0
    add(1, 1, 1, 1, 0, 0); add(0, 0, 0, 1, 0, 0); add(0, 0, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0); add(0, 1, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 0); add(0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 0, 1); add(0, 1, 0, 1, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].xb, tbl[i].v, 1'b0, 4'b0000, tbl[i].ov, tbl[i].clr);
      chk($sformatf("tbl%0d_z", i), z, tbl[i].ez);
      chk($sformatf("tbl%0d_count", i), cnt, tbl[i].ecnt);
    end

    // T3: load 0110 (the x presented with the load is dropped), overlap then non-overlap
    do_reset();
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    pulses = 0;
    foreach (r_bits[i]) begin
      bitin(r_bits[i], 1'b1);
      if (z === 1'b1) pulses++;
    end
    chk("t3_ovl_pulses", pulses, 2);
    step(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    chk("t3_load_z", z, 0);
    chk("t3_load_count", cnt, 2);
    pulses = 0;
    foreach (r_bits[i]) begin
      bitin(r_bits[i], 1'b0);
      if (z === 1'b1) pulses++;
    end
    chk("t3_nonovl_pulses", pulses, 1);

    // T5: saturation of the narrow counter, then clear colliding with a hit
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bitin(1'b1, 1'b1);
      bitin(1'b0, 1'b1);
    end
    chk("t5_count8", cnt, 5);
    chk("t5_count2_sat", cnt2, 3);
    bitin(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    chk("t5_clr_hit_z", z, 1);
    chk("t5_clr_hit_count", cnt, 0);
    chk("t5_clr_hit_count2", cnt2, 0);

    // Wide counter saturation at 255 with an all-zero pattern
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 262; i++) bitin(1'b0, 1'b1);
    chk("sat255_count", cnt, 255);
    bitin(1'b0, 1'b1);
    chk("sat255_hold", cnt, 255);
    chk("sat255_z", z, 1);

    // T6: reset mid-stream discards the partial pattern
    do_reset();
    foreach (t6_bits[i]) bitin(t6_bits[i], 1'b0);
    chk("t6_pre_count", cnt, 1);
    do_reset();
    bitin(1'b0, 1'b1);
    chk("t6_after_rst_z", z, 0);
    pulses = 0;
    bitin(1'b1, 1'b1); pulses += int'(z === 1'b1);
    bitin(1'b0, 1'b1); pulses += int'(z === 1'b1);
    bitin(1'b1, 1'b1); pulses += int'(z === 1'b1);
    bitin(1'b0, 1'b1); pulses += int'(z === 1'b1);
    chk("t6_pulses", pulses, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset();
      end else if (r < 6) begin
        step(1'($urandom), 1'($urandom), 1'b1, pick_pat(), 1'($urandom), 1'b0);
      end else begin
        step(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 4'($urandom),
             1'($urandom), ($urandom_range(0, 29) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  logic r_bits[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic t6_bits[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic logic [3:0] pick_pat();
    case ($urandom_range(0, 4))
      0:       return 4'b1010;
      1:       return 4'b0110;
      2:       return 4'b0000;
      3:       return 4'b1111;
      default: return 4'($urandom);
    endcase
  endfunction

endmodule
